// File: rtl/muldiv_unit_if.sv
// Purpose : request/response bundle between the execute stage and the RV32M mul/div unit.
// Latency : n/a (wires only).
// Backpres: the core must hold off new requests while busy; start is ignored until busy drops.
// Ports   : master = core side (drives start/flush/funct3/op_a/op_b),
//           slave  = unit side (drives busy/done/result).
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Purpose : iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency : DATA_WIDTH+1 cycles from the start edge to done; divide-by-zero/overflow in 1 cycle when EARLY_OUT=1.
// Backpres: busy high while iterating, start ignored then; flush aborts, done is a one-cycle pulse.
// Ports   : clk, rst (async, active-low), bus (muldiv_unit_if.slave: start/flush/funct3/op_a/op_b in,
//           busy/done/result out). result is registered and held until the next done.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit EARLY_OUT  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int            W        = DATA_WIDTH;
  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST     = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]     op;
  logic [W-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*W-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [CW-1:0]  cnt;
  logic           fin;       // all iterations done; next edge registers the result
  logic           neg_main;  // negate product / quotient
  logic           neg_rem;   // negate remainder (sign of dividend)
  logic           ovr;       // special case: ovr_val replaces the computed result
  logic [W-1:0]   ovr_val;
  logic [W-1:0]   res_q;

  // ---------------- request decode (raw operands at start) ----------------
  logic         a_signed, b_signed, neg_a, neg_b;
  logic         div_zero, div_ovf, special;
  logic [W-1:0] mag_a, mag_b, special_val;
  logic         iterating, accept, early;

  always_comb begin
    a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    neg_a    = a_signed && bus.op_a[W-1];
    neg_b    = b_signed && bus.op_b[W-1];
    mag_a    = neg_a ? -bus.op_a : bus.op_a;
    mag_b    = neg_b ? -bus.op_b : bus.op_b;
    div_zero = bus.funct3[2] && (bus.op_b == '0);
    // signed overflow only exists for DIV/REM (funct3[0]=0)
    div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == MOST_NEG) && (bus.op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = bus.funct3[1] ? bus.op_a : '1;
    else          special_val = bus.funct3[1] ? '0 : bus.op_a;
  end

  assign iterating = (state == MUL) || (state == DIV);
  assign accept    = ((state == IDLE) || (state == DONE)) && bus.start && !bus.flush;
  assign early     = accept && special && EARLY_OUT;

  // ---------------- one iteration step and result formatting ----------------
  logic [W:0]     mul_sum, rem_sh, rem_diff;
  logic [2*W-1:0] acc_step, prod_s;
  logic [W-1:0]   quo_s, rem_s, final_val;

  always_comb begin
    // shift-add: add multiplicand into the upper half when multiplier LSB is set, shift right
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    // restoring divide: shift next dividend bit into remainder, subtract, keep if no borrow
    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (op[2]) acc_step = rem_diff[W] ? {rem_sh[W-1:0],   acc[W-2:0], 1'b0}
                                      : {rem_diff[W-1:0], acc[W-2:0], 1'b1};
    else       acc_step = {mul_sum, acc[W-1:1]};

    prod_s = neg_main ? -acc : acc;
    quo_s  = neg_main ? -acc[W-1:0] : acc[W-1:0];
    rem_s  = neg_rem  ? -acc[2*W-1:W] : acc[2*W-1:W];

    if (ovr)        final_val = ovr_val;
    else if (op[2]) final_val = op[1] ? rem_s : quo_s;
    else            final_val = (op[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.flush || !bus.start) state_nxt = IDLE;
        else if (early)              state_nxt = DONE;
        else                         state_nxt = bus.funct3[2] ? DIV : MUL;
      end
      MUL, DIV: begin
        if (bus.flush) state_nxt = IDLE;
        else if (fin)  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = iterating;
    bus.done = (state == DONE);
  end

  assign bus.result = res_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op       <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      fin      <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      ovr      <= 1'b0;
      ovr_val  <= '0;
      res_q    <= '0;
    end else if (accept) begin
      op       <= bus.funct3;
      opnd     <= bus.funct3[2] ? mag_b : mag_a;
      acc      <= {{W{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
      cnt      <= '0;
      fin      <= 1'b0;
      neg_main <= neg_a ^ neg_b;
      neg_rem  <= neg_a;
      ovr      <= special;
      ovr_val  <= special_val;
      if (early) res_q <= special_val;
    end else if (iterating && !bus.flush) begin
      if (fin) begin
        res_q <= final_val;
      end else begin
        acc <= acc_step;
        fin <= (cnt == LAST);
        // counter saturates at terminal count; fin forces the exit
        if (cnt != LAST) cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
